// File: rtl/reg_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_reader                                                    |
// | Purpose  : Walks a fixed window of architectural registers through the   |
// |            register file's combinational read port (BASE, then COUNT     |
// |            registers up or down) and accumulates the values read into a  |
// |            running sum with a sticky unsigned-carry flag.                |
// | Ports    : clock      - sole clock, rising edge                          |
// |            reset      - synchronous, active-low                          |
// |            go         - level start request; sweep runs after go falls   |
// |            direction  - 1 = ascending window, 0 = descending window      |
// |            rdata      - register file read data for regnum (same cycle)  |
// |            regnum     - register file read address                       |
// |            sum        - accumulated total, modulo 2^WIDTH                |
// |            overflow   - sticky carry out of sum for the current sweep    |
// |            done       - sweep complete, sum/overflow final               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module reg_reader #(
  parameter int BASE  = 8,
  parameter int COUNT = 4,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             direction,
  input  logic [WIDTH-1:0] rdata,
  output logic [4:0]       regnum,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic             done
);

  localparam logic [4:0] c_BASE  = 5'(BASE);
  localparam logic [3:0] c_COUNT = 4'(COUNT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_STEP  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [3:0]       r_step;       // current step index k while in S_STEP
  logic [3:0]       w_step_next;
  logic             r_dir;        // direction captured on the START->STEP edge
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf;
  logic             w_load;       // START: sum <= rdata
  logic             w_accum;      // STEP : sum <= sum + rdata
  logic [WIDTH:0]   w_add;        // one extra bit catches the carry
  logic [4:0]       w_addr_up;
  logic [4:0]       w_addr_dn;

  // Window addresses; parameter legality keeps both inside 1..31.
  assign w_addr_up = c_BASE + {1'b0, r_step};
  assign w_addr_dn = c_BASE - {1'b0, r_step};
  assign w_add     = {1'b0, r_sum} + {1'b0, rdata};

  // State and step-counter register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_step  <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_next;
    end
  end

  // Next-state and state-decoded outputs. regnum/done depend on state only.
  always_comb begin
    w_state_next = r_state;
    w_step_next  = r_step;
    regnum       = 5'd0;
    done         = 1'b0;
    w_load       = 1'b0;
    w_accum      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (go) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        regnum = c_BASE;
        w_load = 1'b1;
        if (!go) begin
          w_state_next = S_STEP;
          w_step_next  = 4'd1;
        end
      end
      S_STEP: begin
        // go and the live direction input are deliberately ignored here.
        regnum  = r_dir ? w_addr_up : w_addr_dn;
        w_accum = 1'b1;
        if (r_step == c_COUNT) begin
          w_state_next = S_DONE;
        end else begin
          w_step_next = r_step + 4'd1;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (go) begin
          w_state_next = S_START;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: START reloads (only the final START cycle's value survives),
  // STEP accumulates with a sticky carry. Direction is captured on the same
  // edge that leaves START.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sum <= '0;
      r_ovf <= 1'b0;
      r_dir <= 1'b0;
    end else if (w_load) begin
      r_sum <= rdata;
      r_ovf <= 1'b0;
      if (!go) begin
        r_dir <= direction;
      end
    end else if (w_accum) begin
      r_sum <= w_add[WIDTH-1:0];
      r_ovf <= r_ovf | w_add[WIDTH];
    end
  end

  assign sum      = r_sum;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_reg_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_reg_reader                                                 |
// | Purpose  : Self-checking bench for reg_reader. A bench-side register     |
// |            file feeds rdata; a sweep-level model predicts regnum, done,  |
// |            sum and overflow every cycle; directed sweeps add literal     |
// |            expectations.                                                 |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_reg_reader;

  localparam int BASE  = 8;
  localparam int COUNT = 4;
  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             go;
  logic             direction;
  logic [WIDTH-1:0] rdata;
  logic [4:0]       regnum;
  logic [WIDTH-1:0] sum;
  logic             overflow;
  logic             done;

  logic [WIDTH-1:0] regs [32];

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  always #5 clock = ~clock;

  assign rdata = regs[regnum];

  reg_reader #(.BASE(BASE), .COUNT(COUNT), .WIDTH(WIDTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .go       (go),
    .direction(direction),
    .rdata    (rdata),
    .regnum   (regnum),
    .sum      (sum),
    .overflow (overflow),
    .done     (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- sweep-level model ----------------
  // phase: -1 idle, 0 start, 1..COUNT = k-th read after BASE, COUNT+1 done.
  // The total is kept wide; overflow is simply "total no longer fits".
  int          m_phase = -1;
  logic [63:0] m_total = 64'd0;
  bit          m_dir   = 1'b0;

  function automatic int m_addr(input int ph, input bit d);
    if (ph == 0)              return BASE;
    if (ph < 0 || ph > COUNT) return 0;
    return d ? BASE + ph : BASE - ph;
  endfunction

  always @(posedge clock) begin
    if (!reset) begin
      m_phase = -1;
      m_total = 64'd0;
      m_dir   = 1'b0;
    end else if (m_phase == -1 || m_phase == COUNT + 1) begin
      if (go) m_phase = 0;
    end else if (m_phase == 0) begin
      m_total = {32'd0, regs[BASE]};
      if (!go) begin
        m_phase = 1;
        m_dir   = direction;
      end
    end else begin
      m_total = m_total + {32'd0, regs[m_addr(m_phase, m_dir)]};
      m_phase = m_phase + 1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_regnum",   64'(regnum),   64'(m_addr(m_phase, m_dir)));
      check("cyc_done",     64'(done),     64'(m_phase == COUNT + 1));
      check("cyc_sum",      64'(sum),      {32'd0, m_total[31:0]});
      check("cyc_overflow", 64'(overflow), 64'(m_total[63:32] != 32'd0));
    end
  end

  // ---------------- stimulus ----------------
  int trace [6];
  int lat;

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic set_win(input int first, input logic [31:0] a, b, c, d, e);
    regs[first] = a; regs[first+1] = b; regs[first+2] = c;
    regs[first+3] = d; regs[first+4] = e;
  endtask

  // Wait (bounded) for done after go has been dropped; record regnum trace.
  task automatic wait_done(output int l);
    l = 0;
    trace[0] = int'(regnum);
    while (!done && l < 20) begin
      step();
      l++;
      if (l < 6) trace[l] = int'(regnum);
    end
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input bit dir, input int golen, output int l);
    direction = dir;
    go = 1'b1;
    repeat (golen) step();
    go = 1'b0;
    wait_done(l);
  endtask

  initial begin
    reset = 1'b0; go = 1'b0; direction = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    step(); step();
    check("rst_regnum",   64'(regnum),   64'd0);
    check("rst_sum",      64'(sum),      64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_done",     64'(done),     64'd0);
    chk_en = 1'b1;
    reset = 1'b1;
    step(); step();
    check("idle_regnum", 64'(regnum), 64'd0);

    // Up sweep
    set_win(8, 1, 2, 3, 4, 5);
    run(1'b1, 1, lat);
    check("up_latency", 64'(lat), 64'd5);
    check("up_sum", 64'(sum), 64'd15);
    check("up_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 6; i++) check("up_trace", 64'(trace[i]), 64'((i < 5) ? 8 + i : 0));

    // Down sweep
    set_win(4, 10, 20, 30, 40, 50);
    run(1'b0, 1, lat);
    check("dn_latency", 64'(lat), 64'd5);
    check("dn_sum", 64'(sum), 64'd150);
    check("dn_ovf", 64'(overflow), 64'd0);
    for (int i = 0; i < 6; i++) check("dn_trace", 64'(trace[i]), 64'((i < 5) ? 8 - i : 0));

    // Overflow then clean rerun
    set_win(8, 32'hFFFF_FFFF, 2, 0, 0, 0);
    run(1'b1, 1, lat);
    check("ov_sum", 64'(sum), 64'd1);
    check("ov_ovf", 64'(overflow), 64'd1);
    set_win(8, 0, 0, 0, 0, 0);
    run(1'b1, 1, lat);
    check("zero_sum", 64'(sum), 64'd0);
    check("zero_ovf", 64'(overflow), 64'd0);

    // go/direction glitches during STEP(2)
    set_win(8, 1, 2, 3, 4, 5);
    direction = 1'b1;
    go = 1'b1;
    step();
    go = 1'b0;
    step(); step();
    direction = 1'b0;
    go = 1'b1;
    wait_done(lat);
    check("gl_latency", 64'(lat), 64'd3);
    check("gl_sum", 64'(sum), 64'd15);
    check("gl_trace3", 64'(trace[1]), 64'd11);
    step();
    check("gl_restart_done", 64'(done), 64'd0);
    check("gl_restart_regnum", 64'(regnum), 64'd8);
    direction = 1'b1;
    go = 1'b0;
    wait_done(lat);
    check("gl_rerun_sum", 64'(sum), 64'd15);

    // Long go: reg 8 changes 3 -> 7 on the final START cycle
    set_win(8, 3, 0, 0, 0, 0);
    direction = 1'b1;
    go = 1'b1;
    repeat (5) step();
    check("lg_mid_sum", 64'(sum), 64'd3);
    step();
    regs[8] = 7;
    go = 1'b0;
    wait_done(lat);
    check("lg_latency", 64'(lat), 64'd5);
    check("lg_sum", 64'(sum), 64'd7);

    // Reset during STEP(3)
    set_win(8, 1, 2, 3, 4, 5);
    direction = 1'b1;
    go = 1'b1;
    step();
    go = 1'b0;
    step(); step(); step();
    check("rm_in_step3", 64'(regnum), 64'd11);
    reset = 1'b0;
    step();
    check("rm_regnum", 64'(regnum), 64'd0);
    check("rm_sum", 64'(sum), 64'd0);
    check("rm_ovf", 64'(overflow), 64'd0);
    check("rm_done", 64'(done), 64'd0);
    reset = 1'b1;
    step();
    check("rm_idle_regnum", 64'(regnum), 64'd0);
    run(1'b1, 1, lat);
    check("rm_latency", 64'(lat), 64'd5);
    check("rm_sum_after", 64'(sum), 64'd15);

    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
